thread_lsu: RTL
===============

Name: thread_lsu

Overview:
- Per-thread load/store unit: the memory-side producer for the thread register file.
- Consumes the rs (address) and rt (store data) values the register file latches in REQUEST.
- Runs a valid/ready transaction to the memory controller and returns lsu_out, which the register file writes to rd in UPDATE (MEMORY mux select).
- One instance per thread, beside the ALU; the core scheduler polls lsu_state to leave WAIT.

Parameters:
- DATA_BITS, 8, width of rt, read/write data and lsu_out
- ADDR_BITS, 8, width of memory address (taken from rs[ADDR_BITS-1:0])

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  thread active in current block; low = unit frozen
- core_state  input  3  scheduler state (REQUEST=3'b011, WAIT=3'b100, UPDATE=3'b110)
- decoded_mem_read_enable  input  1  current instruction is LDR
- decoded_mem_write_enable  input  1  current instruction is STR
- rs  input  DATA_BITS  address operand from register file
- rt  input  DATA_BITS  store data operand from register file
- mem_read_valid  output  1  read request valid
- mem_read_address  output  ADDR_BITS  read address
- mem_read_ready  input  1  read accepted, data on mem_read_data this cycle
- mem_read_data  input  DATA_BITS  read return data
- mem_write_valid  output  1  write request valid
- mem_write_address  output  ADDR_BITS  write address
- mem_write_data  output  DATA_BITS  write data
- mem_write_ready  input  1  write accepted this cycle
- lsu_state  output  2  IDLE=00, REQUESTING=01, WAITING=10, DONE=11
- lsu_out  output  DATA_BITS  last loaded value

Behaviour:
- Reset (synchronous, active-high):
  - Every output goes to 0: lsu_state=IDLE, both valids, addresses, mem_write_data, lsu_out.
  - The internal op flag clears.
  - Reset mid-transaction abandons the request; valid is low the cycle after reset.
- enable low: state, op flag and all outputs hold; no transitions; ready inputs ignored.
- IDLE:
  - If core_state==REQUEST and (read_en | write_en): latch op into is_write (write only when write_en & !read_en; read has precedence if both) and go to REQUESTING.
  - Otherwise stay in IDLE.
- REQUESTING (exactly 1 cycle; rs/rt are valid from the register file here):
  - Read: mem_read_valid<=1, mem_read_address<=rs.
  - Write: mem_write_valid<=1, mem_write_address<=rs, mem_write_data<=rt.
  - Go to WAITING.
  - Ready inputs are ignored in this state.
- WAITING:
  - Valid, address and data stay stable until the matching ready is sampled high.
  - Read: on mem_read_ready, lsu_out<=mem_read_data, mem_read_valid<=0, go to DONE.
  - Write: on mem_write_ready, mem_write_valid<=0, go to DONE.
  - The ready of the non-active channel is ignored.
  - Ready high in the first WAITING cycle completes with zero wait.
  - No timeout.
- DONE:
  - Hold until core_state==UPDATE, then go to IDLE.
  - lsu_out is stable through UPDATE so the register file captures it.
- lsu_out changes only on read completion; stores leave it untouched.
- Decoded enables and rs/rt may change after REQUESTING without effect.
- core_state==UPDATE outside DONE has no effect.
- Minimum latency, with REQUEST sampled at cycle 0: REQUESTING in cycle 1, valid high in cycle 2, ready in cycle 2 gives DONE and lsu_out valid in cycle 3.
- Address truncation: only the low ADDR_BITS of rs are used; no wrap check.

Decomposition:
- Shared package gpu_pkg:
  - core_state localparams (IDLE..DONE, 3 bits)
  - lsu_state localparams (2 bits)
  - register-input mux codes (ARITHMETIC/MEMORY/CONSTANT/MOVC)
- No sub-module; one FSM plus output registers.

Test Plan:
- Load: read_en=1, core_state=REQUEST, rs=8'h2A; ready held low 3 cycles, then mem_read_data=8'h5C with ready -> mem_read_valid=1 with address 8'h2A stable for 3+ cycles; lsu_out=8'h5C; lsu_state=DONE; IDLE after UPDATE.
- Store: write_en=1, rs=8'h10, rt=8'hEE, ready in first WAITING cycle -> mem_write_valid pulse of 1 cycle with address 8'h10, data 8'hEE; lsu_out unchanged; DONE on cycle 3.
- Both enables set: rs=8'h01 -> read channel used only; mem_write_valid stays 0.
- enable dropped in WAITING for 2 cycles while ready=1 -> no completion and valid held; completes once enable=1 with ready.
- Reset asserted in WAITING -> next cycle all outputs 0, lsu_state=00; a later LDR runs normally.
- Back-to-back LDR 8'h33 then STR -> lsu_out=8'h33 persists through the store; no request is issued from DONE until UPDATE is seen.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared encodings for the GPU core: scheduler states, LSU states and
// register-file input mux selects.
package gpu_pkg;

    localparam logic [2:0] CORE_IDLE    = 3'b000;
    localparam logic [2:0] CORE_FETCH   = 3'b001;
    localparam logic [2:0] CORE_DECODE  = 3'b010;
    localparam logic [2:0] CORE_REQUEST = 3'b011;
    localparam logic [2:0] CORE_WAIT    = 3'b100;
    localparam logic [2:0] CORE_EXECUTE = 3'b101;
    localparam logic [2:0] CORE_UPDATE  = 3'b110;
    localparam logic [2:0] CORE_DONE    = 3'b111;

    typedef enum logic [1:0] {
        LSU_IDLE       = 2'b00,
        LSU_REQUESTING = 2'b01,
        LSU_WAITING    = 2'b10,
        LSU_DONE       = 2'b11
    } lsu_state_e;

    localparam logic [1:0] REG_INPUT_ARITHMETIC = 2'b00;
    localparam logic [1:0] REG_INPUT_MEMORY     = 2'b01;
    localparam logic [1:0] REG_INPUT_CONSTANT   = 2'b10;
    localparam logic [1:0] REG_INPUT_MOVC       = 2'b11;

endpackage

// File: rtl/thread_lsu.sv
// Per-thread load/store unit: turns an LDR/STR latched in REQUEST into one
// valid/ready memory transaction and holds the loaded value for UPDATE.
module thread_lsu
    import gpu_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           core_state,
    input  logic                 decoded_mem_read_enable,
    input  logic                 decoded_mem_write_enable,
    input  logic [DATA_BITS-1:0] rs,
    input  logic [DATA_BITS-1:0] rt,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    input  logic                 mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,
    output logic                 mem_write_valid,
    output logic [ADDR_BITS-1:0] mem_write_address,
    output logic [DATA_BITS-1:0] mem_write_data,
    input  logic                 mem_write_ready,
    output logic [1:0]           lsu_state,
    output logic [DATA_BITS-1:0] lsu_out
);

    lsu_state_e           state_q, state_d;
    logic                 is_write_q, is_write_d;
    logic                 read_valid_q, read_valid_d;
    logic [ADDR_BITS-1:0] read_addr_q, read_addr_d;
    logic                 write_valid_q, write_valid_d;
    logic [ADDR_BITS-1:0] write_addr_q, write_addr_d;
    logic [DATA_BITS-1:0] write_data_q, write_data_d;
    logic [DATA_BITS-1:0] lsu_out_q, lsu_out_d;

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no path leaves a
        // variable unassigned and no latch is inferred.
        state_d       = state_q;
        is_write_d    = is_write_q;
        read_valid_d  = read_valid_q;
        read_addr_d   = read_addr_q;
        write_valid_d = write_valid_q;
        write_addr_d  = write_addr_q;
        write_data_d  = write_data_q;
        lsu_out_d     = lsu_out_q;

        if (enable) begin
            unique case (state_q)
                LSU_IDLE: begin
                    if (core_state == CORE_REQUEST &&
                        (decoded_mem_read_enable || decoded_mem_write_enable)) begin
                        // Read wins when both enables are set.
                        is_write_d = decoded_mem_write_enable && !decoded_mem_read_enable;
                        state_d    = LSU_REQUESTING;
                    end
                end
                LSU_REQUESTING: begin
                    if (is_write_q) begin
                        write_valid_d = 1'b1;
                        write_addr_d  = rs[ADDR_BITS-1:0];
                        write_data_d  = rt;
                    end else begin
                        read_valid_d = 1'b1;
                        read_addr_d  = rs[ADDR_BITS-1:0];
                    end
                    state_d = LSU_WAITING;
                end
                LSU_WAITING: begin
                    if (is_write_q) begin
                        if (mem_write_ready) begin
                            write_valid_d = 1'b0;
                            state_d       = LSU_DONE;
                        end
                    end else if (mem_read_ready) begin
                        lsu_out_d    = mem_read_data;
                        read_valid_d = 1'b0;
                        state_d      = LSU_DONE;
                    end
                end
                LSU_DONE: begin
                    if (core_state == CORE_UPDATE) state_d = LSU_IDLE;
                end
                default: state_d = LSU_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value of every other flop.
        if (reset) begin
            state_q       <= LSU_IDLE;
            is_write_q    <= 1'b0;
            read_valid_q  <= 1'b0;
            read_addr_q   <= '0;
            write_valid_q <= 1'b0;
            write_addr_q  <= '0;
            write_data_q  <= '0;
            lsu_out_q     <= '0;
        end else begin
            state_q       <= state_d;
            is_write_q    <= is_write_d;
            read_valid_q  <= read_valid_d;
            read_addr_q   <= read_addr_d;
            write_valid_q <= write_valid_d;
            write_addr_q  <= write_addr_d;
            write_data_q  <= write_data_d;
            lsu_out_q     <= lsu_out_d;
        end
    end

    assign lsu_state         = state_q;
    assign mem_read_valid    = read_valid_q;
    assign mem_read_address  = read_addr_q;
    assign mem_write_valid   = write_valid_q;
    assign mem_write_address = write_addr_q;
    assign mem_write_data    = write_data_q;
    assign lsu_out           = lsu_out_q;

endmodule
